rcfg_rom_streamer: RTL and testbench

- Consumes the packed reconfiguration ROM produced by the per-IP streamer parameter package.
- Walks one selected configuration profile entry by entry.
- For each entry, performs a masked read-modify-write on the transceiver Avalon-MM reconfiguration interface.
- Sits between the user/DPRIO arbiter and the native PHY reconfig port; holds the ROM externally via a synchronous read port.

---
 rtl/rcfg_rom_streamer.sv | 188 ++++++++++++++++++
 tb/tb_rcfg_rom_streamer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcfg_rom_streamer.sv
// Walks one profile of the packed reconfiguration ROM, doing a masked read-modify-write per entry.
// Build option RCFG_STRM_SKIP_FULL_MASK_EN: entries with mask 8'hFF are written without the read.
module rcfg_rom_streamer #(
    parameter int ROM_DATA_WIDTH = 26,
    parameter int ROM_DEPTH      = 6,
    parameter int NUM_PROFILES   = 2,
    parameter int PROFILE_DEPTH  = 3,
    parameter int ADDR_W         = ROM_DATA_WIDTH - 16,
    // may be widened so out-of-range selects can reach the block
    parameter int CFG_SEL_W      = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1,
    parameter int ROM_ADDR_W     = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
    input  logic                      reconfig_clk,
    input  logic                      reconfig_reset,
    input  logic [CFG_SEL_W-1:0]      cfg_sel,
    input  logic                      cfg_start,
    output logic                      cfg_busy,
    output logic                      cfg_done,
    output logic                      cfg_error,
    output logic [ROM_ADDR_W-1:0]     rom_addr,
    output logic                      rom_rd,
    input  logic [ROM_DATA_WIDTH-1:0] rom_data,
    output logic [ADDR_W-1:0]         avmm_address,
    output logic                      avmm_read,
    output logic                      avmm_write,
    output logic [31:0]               avmm_writedata,
    input  logic [31:0]               avmm_readdata,
    input  logic                      avmm_waitrequest
);

    localparam int IDX_W = (PROFILE_DEPTH > 1) ? $clog2(PROFILE_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROM_RD,
        S_ROM_WAIT,
        S_DECODE,
        S_AV_RD,
        S_AV_WR,
        S_FINISH
    } state_t;

    state_t                    state_q;
    logic [ROM_ADDR_W-1:0]     base_q;
    logic [ROM_ADDR_W-1:0]     base_d;
    logic [ROM_ADDR_W-1:0]     rom_addr_q;
    logic                      rom_rd_q;
    logic [IDX_W-1:0]          idx_q;
    logic [IDX_W-1:0]          idx_d;
    logic [ROM_DATA_WIDTH-1:0] entry_q;
    logic [ADDR_W-1:0]         avmm_address_q;
    logic                      avmm_read_q;
    logic                      avmm_write_q;
    logic [7:0]                wdata_q;
    logic [7:0]                merged_d;
    logic                      cfg_busy_q;
    logic                      cfg_done_q;
    logic                      cfg_error_q;

    logic                      sel_ok;
    logic                      is_term;
    logic                      is_last;
    logic [ADDR_W-1:0]         e_addr;
    logic [7:0]                e_mask;
    logic [7:0]                e_data;
    logic                      unused_rd_hi;

    assign sel_ok   = 32'(cfg_sel) < 32'(NUM_PROFILES);
    assign base_d   = ROM_ADDR_W'(32'(cfg_sel) * 32'(PROFILE_DEPTH));
    assign idx_d    = idx_q + 1'b1;

    assign e_addr   = entry_q[ROM_DATA_WIDTH-1 -: ADDR_W];
    assign e_mask   = entry_q[15:8];
    assign e_data   = entry_q[7:0];
    assign is_term  = &entry_q;
    assign is_last  = (idx_q == IDX_W'(PROFILE_DEPTH - 1));
    assign merged_d = (avmm_readdata[7:0] & ~e_mask) | (e_data & e_mask);

    assign unused_rd_hi = ^avmm_readdata[31:8];

    always_ff @(posedge reconfig_clk or posedge reconfig_reset) begin
        if (reconfig_reset) begin
            state_q        <= S_IDLE;
            base_q         <= '0;
            rom_addr_q     <= '0;
            rom_rd_q       <= 1'b0;
            idx_q          <= '0;
            entry_q        <= '0;
            avmm_address_q <= '0;
            avmm_read_q    <= 1'b0;
            avmm_write_q   <= 1'b0;
            wdata_q        <= '0;
            cfg_busy_q     <= 1'b0;
            cfg_done_q     <= 1'b0;
            cfg_error_q    <= 1'b0;
        end else begin
            cfg_done_q  <= 1'b0;
            cfg_error_q <= 1'b0;
            rom_rd_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (cfg_start) begin
                        if (sel_ok) begin
                            base_q     <= base_d;
                            idx_q      <= '0;
                            rom_addr_q <= base_d;
                            rom_rd_q   <= 1'b1;
                            cfg_busy_q <= 1'b1;
                            state_q    <= S_ROM_RD;
                        end else begin
                            cfg_error_q <= 1'b1;
                        end
                    end
                end

                S_ROM_RD: begin
                    state_q <= S_ROM_WAIT;
                end

                S_ROM_WAIT: begin
                    entry_q <= rom_data;
                    state_q <= S_DECODE;
                end

                // a profile with no terminator ends after its last slot without executing it
                S_DECODE: begin
                    if (is_term || is_last) begin
                        state_q <= S_FINISH;
                    end
`ifdef RCFG_STRM_SKIP_FULL_MASK_EN
                    else if (e_mask == 8'hFF) begin
                        avmm_address_q <= e_addr;
                        wdata_q        <= e_data;
                        avmm_write_q   <= 1'b1;
                        state_q        <= S_AV_WR;
                    end
`endif
                    else begin
                        avmm_address_q <= e_addr;
                        avmm_read_q    <= 1'b1;
                        state_q        <= S_AV_RD;
                    end
                end

                S_AV_RD: begin
                    if (!avmm_waitrequest) begin
                        avmm_read_q  <= 1'b0;
                        wdata_q      <= merged_d;
                        avmm_write_q <= 1'b1;
                        state_q      <= S_AV_WR;
                    end
                end

                S_AV_WR: begin
                    if (!avmm_waitrequest) begin
                        avmm_write_q <= 1'b0;
                        idx_q        <= idx_d;
                        rom_addr_q   <= base_q + ROM_ADDR_W'(idx_d);
                        rom_rd_q     <= 1'b1;
                        state_q      <= S_ROM_RD;
                    end
                end

                S_FINISH: begin
                    cfg_busy_q <= 1'b0;
                    cfg_done_q <= 1'b1;
                    state_q    <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_busy       = cfg_busy_q;
    assign cfg_done       = cfg_done_q;
    assign cfg_error      = cfg_error_q;
    assign rom_addr       = rom_addr_q;
    assign rom_rd         = rom_rd_q;
    assign avmm_address   = avmm_address_q;
    assign avmm_read      = avmm_read_q;
    assign avmm_write     = avmm_write_q;
    assign avmm_writedata = {24'h0, wdata_q};

endmodule

// File: tb/tb_rcfg_rom_streamer.sv
// Self-checking bench for rcfg_rom_streamer: ROM and reconfig-slave models, transaction scoreboard.
module tb_rcfg_rom_streamer;

    typedef struct packed {
        logic       wr;
        logic [9:0] addr;
        logic [7:0] data;
    } tx_t;

    typedef struct {
        logic [1:0] sel;
        int         mode;
        int         ws;
        int         exp_busy;
        bit         exp_err;
        int         n_tx;
        tx_t        tx[4];
    } vec_t;

    logic        reconfig_clk = 1'b0;
    logic        reconfig_reset;
    logic [1:0]  cfg_sel;
    logic        cfg_start;
    logic        cfg_busy, cfg_done, cfg_error;
    logic [2:0]  rom_addr;
    logic        rom_rd;
    logic [25:0] rom_data;
    logic [9:0]  avmm_address;
    logic        avmm_read, avmm_write;
    logic [31:0] avmm_writedata, avmm_readdata;
    logic        avmm_waitrequest;

    logic [25:0] rom_mem [6];
    int          ws = 0;
    int          slave_mode = 0;
    int          ws_cnt = 0;

    tx_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    vec_t        vec[4];

    always #5 reconfig_clk = ~reconfig_clk;

    rcfg_rom_streamer #(.CFG_SEL_W(2)) dut (
        .reconfig_clk     (reconfig_clk),
        .reconfig_reset   (reconfig_reset),
        .cfg_sel          (cfg_sel),
        .cfg_start        (cfg_start),
        .cfg_busy         (cfg_busy),
        .cfg_done         (cfg_done),
        .cfg_error        (cfg_error),
        .rom_addr         (rom_addr),
        .rom_rd           (rom_rd),
        .rom_data         (rom_data),
        .avmm_address     (avmm_address),
        .avmm_read        (avmm_read),
        .avmm_write       (avmm_write),
        .avmm_writedata   (avmm_writedata),
        .avmm_readdata    (avmm_readdata),
        .avmm_waitrequest (avmm_waitrequest)
    );

    always @(posedge reconfig_clk) begin
        if (rom_rd) rom_data <= rom_mem[rom_addr];
    end

    // slave stalls each request for ws cycles, then accepts
    always @(posedge reconfig_clk) begin
        if (avmm_read || avmm_write) ws_cnt <= (ws_cnt < ws) ? ws_cnt + 1 : 0;
        else                         ws_cnt <= 0;
    end
    assign avmm_waitrequest = (avmm_read || avmm_write) && (ws_cnt < ws);

    function automatic logic [7:0] slave_val(input logic [9:0] a, input int mode);
        if (mode == 0 && a == 10'h135) return 8'hFF;
        if (mode == 0 && a == 10'h100) return 8'hA5;
        return 8'h00;
    endfunction
    assign avmm_readdata = {24'h0, slave_val(avmm_address, slave_mode)};

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        int         hold = 0;
        logic [9:0] h_addr = '0;
        logic [31:0] h_data = '0;
        tx_t        t;
        forever begin
            @(negedge reconfig_clk);
            if (avmm_read || avmm_write) begin
                if (hold == 0) begin
                    h_addr = avmm_address;
                    h_data = avmm_writedata;
                end
                hold++;
                if (!avmm_waitrequest) begin
                    check_eq("rd_wr_exclusive", 32'(avmm_read & avmm_write), 0);
                    check_eq("hold_cycles", hold, ws + 1);
                    check_eq("addr_stable", avmm_address, 32'(h_addr));
                    if (avmm_write) check_eq("wdata_stable", avmm_writedata, h_data);
                    check_eq("txn_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        t = exp_q.pop_front();
                        check_eq("txn_kind_wr", 32'(avmm_write), 32'(t.wr));
                        check_eq("txn_addr", 32'(avmm_address), 32'(t.addr));
                        if (t.wr) check_eq("txn_wdata", avmm_writedata, {24'h0, t.data});
                    end
                    hold = 0;
                end
            end else begin
                hold = 0;
            end
        end
    endtask

    task automatic run(input logic [1:0] sel, input int exp_busy, input bit exp_err,
                       input bit exp_bus, input int restart_at);
        int   busy_cnt = 0, done_cnt = 0, err_cnt = 0, tail = -1;
        bit   any_bus = 0, got_ra = 0;
        logic [2:0] first_ra = '0;
        @(posedge reconfig_clk); #1;
        cfg_sel   = sel;
        cfg_start = 1'b1;
        @(posedge reconfig_clk); #1;
        cfg_start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (cfg_busy)  busy_cnt++;
            if (cfg_done)  done_cnt++;
            if (cfg_error) err_cnt++;
            if (avmm_read || avmm_write) any_bus = 1;
            if (rom_rd && !got_ra) begin
                got_ra   = 1;
                first_ra = rom_addr;
            end
            if (c == restart_at) begin
                cfg_sel   = ~sel;
                cfg_start = 1'b1;
            end else begin
                cfg_start = 1'b0;
            end
            if ((cfg_done || cfg_error) && tail < 0) tail = 3;
            if (tail == 0) break;
            if (tail > 0) tail--;
            @(posedge reconfig_clk); #1;
        end
        check_eq("completed_in_budget", 32'(tail == 0), 1);
        check_eq("busy_cycles", busy_cnt, exp_busy);
        check_eq("done_pulses", done_cnt, exp_err ? 0 : 1);
        check_eq("error_pulses", err_cnt, exp_err ? 1 : 0);
        check_eq("bus_activity", 32'(any_bus), 32'(exp_bus));
        check_eq("pending_txns", exp_q.size(), 0);
        if (!exp_err) check_eq("first_rom_addr", 32'(first_ra), 32'(sel) * 3);
        exp_q.delete();
    endtask

    initial begin
        rom_mem[0] = {10'h135, 8'h0F, 8'h03};
        rom_mem[1] = {10'h13A, 8'h3C, 8'h28};
        rom_mem[2] = 26'h3FF_FFFF;
        rom_mem[3] = {10'h135, 8'h0F, 8'h0C};
        rom_mem[4] = {10'h13A, 8'hF0, 8'h20};
        rom_mem[5] = 26'h3FF_FFFF;

        vec[0] = '{sel: 2'd0, mode: 0, ws: 0, exp_busy: 14, exp_err: 1'b0, n_tx: 4,
                   tx: '{'{1'b0, 10'h135, 8'h00}, '{1'b1, 10'h135, 8'hF3},
                         '{1'b0, 10'h13A, 8'h00}, '{1'b1, 10'h13A, 8'h28}}};
        vec[1] = '{sel: 2'd1, mode: 1, ws: 0, exp_busy: 14, exp_err: 1'b0, n_tx: 4,
                   tx: '{'{1'b0, 10'h135, 8'h00}, '{1'b1, 10'h135, 8'h0C},
                         '{1'b0, 10'h13A, 8'h00}, '{1'b1, 10'h13A, 8'h20}}};
        vec[2] = '{sel: 2'd0, mode: 0, ws: 3, exp_busy: 26, exp_err: 1'b0, n_tx: 4,
                   tx: '{'{1'b0, 10'h135, 8'h00}, '{1'b1, 10'h135, 8'hF3},
                         '{1'b0, 10'h13A, 8'h00}, '{1'b1, 10'h13A, 8'h28}}};
        vec[3] = '{sel: 2'd2, mode: 0, ws: 0, exp_busy: 0, exp_err: 1'b1, n_tx: 0,
                   tx: '{'{1'b0, 10'h0, 8'h0}, '{1'b0, 10'h0, 8'h0},
                         '{1'b0, 10'h0, 8'h0}, '{1'b0, 10'h0, 8'h0}}};

        reconfig_reset = 1'b1;
        cfg_start      = 1'b0;
        cfg_sel        = '0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge reconfig_clk);
        #1;
        check_eq("rst_busy",   32'(cfg_busy), 0);
        check_eq("rst_done",   32'(cfg_done), 0);
        check_eq("rst_error",  32'(cfg_error), 0);
        check_eq("rst_rom_rd", 32'(rom_rd), 0);
        check_eq("rst_rom_addr", 32'(rom_addr), 0);
        check_eq("rst_read",   32'(avmm_read), 0);
        check_eq("rst_write",  32'(avmm_write), 0);
        check_eq("rst_addr",   32'(avmm_address), 0);
        check_eq("rst_wdata",  avmm_writedata, 0);
        reconfig_reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            slave_mode = vec[v].mode;
            ws         = vec[v].ws;
            for (int k = 0; k < vec[v].n_tx; k++) exp_q.push_back(vec[v].tx[k]);
            run(vec[v].sel, vec[v].exp_busy, vec[v].exp_err, vec[v].n_tx > 0, -1);
        end

        // start pulse with a different select while busy must be ignored
        slave_mode = 0;
        ws         = 0;
        for (int k = 0; k < 4; k++) exp_q.push_back(vec[0].tx[k]);
        run(2'd0, 14, 1'b0, 1'b1, 4);

        // reset while entry 0 write is stalled
        slave_mode = 1;
        ws         = 3;
        exp_q.push_back(vec[1].tx[0]);
        @(posedge reconfig_clk); #1;
        cfg_sel   = 2'd1;
        cfg_start = 1'b1;
        @(posedge reconfig_clk); #1;
        cfg_start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (avmm_write) break;
            @(posedge reconfig_clk); #1;
        end
        check_eq("write_before_reset", 32'(avmm_write), 1);
        #2 reconfig_reset = 1'b1;
        #1;
        check_eq("async_rst_write", 32'(avmm_write), 0);
        check_eq("async_rst_busy",  32'(cfg_busy), 0);
        check_eq("async_rst_read",  32'(avmm_read), 0);
        check_eq("pending_after_rst", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge reconfig_clk);
        #1 reconfig_reset = 1'b0;
        ws = 0;
        for (int k = 0; k < 4; k++) exp_q.push_back(vec[1].tx[k]);
        run(2'd1, 14, 1'b0, 1'b1, -1);

        // full-mask entry followed by terminator
        rom_mem[0] = {10'h100, 8'hFF, 8'h5A};
        rom_mem[1] = 26'h3FF_FFFF;
        slave_mode = 0;
        ws         = 0;
`ifdef RCFG_STRM_SKIP_FULL_MASK_EN
        exp_q.push_back('{1'b1, 10'h100, 8'h5A});
        run(2'd0, 8, 1'b0, 1'b1, -1);
`else
        exp_q.push_back('{1'b0, 10'h100, 8'h00});
        exp_q.push_back('{1'b1, 10'h100, 8'h5A});
        run(2'd0, 9, 1'b0, 1'b1, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
